// File: rtl/histogram_pkg.sv
// Shared types and timing constants for the histogram control path.
// Every other histogram file imports this package.
package histogram_pkg;

  localparam int PIXELS_PER_PAIR  = 32;
  localparam int CYCLES_PER_PIXEL = 5;
  localparam int CYCLES_PER_PAIR  =
    3 + CYCLES_PER_PIXEL * PIXELS_PER_PAIR;

  typedef enum logic [3:0] {
    IDLE,
    SET_IN,
    WAIT_IN,
    LATCH_IN,
    SET_SCR,
    WAIT_SCR,
    LATCH_SCR,
    WRITE,
    SHIFT,
    DONE
  } state_e;

  typedef struct packed {
    logic set_in;
    logic rd_in;
    logic set_scr;
    logic rd_scr;
    logic wr_scr;
    logic shift;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode: at most one strobe per state.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    unique case (s)
      IDLE:      c = '0;
      SET_IN:    begin c.set_in  = 1'b1; c.busy = 1'b1; end
      WAIT_IN:   c.busy = 1'b1;
      LATCH_IN:  begin c.rd_in   = 1'b1; c.busy = 1'b1; end
      SET_SCR:   begin c.set_scr = 1'b1; c.busy = 1'b1; end
      WAIT_SCR:  c.busy = 1'b1;
      LATCH_SCR: begin c.rd_scr  = 1'b1; c.busy = 1'b1; end
      WRITE:     begin c.wr_scr  = 1'b1; c.busy = 1'b1; end
      SHIFT:     begin c.shift   = 1'b1; c.busy = 1'b1; end
      DONE:      c.done = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/histogram_control_path.sv
// Histogram pass sequencer: walks input pairs and the per-pixel
// read/modify/write loop, counting completed pairs.
module histogram_control_path #(
  parameter int NUM_PAIRS       = 128,
  parameter int PIXELS_PER_PAIR = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        all_pixel_written,
  output logic        set_read_address_input_mem,
  output logic        read_data_ready_input_mem,
  output logic        set_read_address_scratch_mem,
  output logic        read_data_ready_scratch_mem,
  output logic        set_write_address_scratch_mem,
  output logic        shift_scratch_memory_rw_address,
  output logic        busy,
  output logic        done,
  output logic [15:0] pair_count
);
  import histogram_pkg::*;

  localparam int PAIR_CYCLES =
    3 + CYCLES_PER_PIXEL * PIXELS_PER_PAIR;
  localparam logic [15:0] LAST_PAIR = 16'(NUM_PAIRS);

  if (NUM_PAIRS < 1 || NUM_PAIRS > 65535) begin : g_bad_np
    $error("NUM_PAIRS must be 1..65535");
  end
  if (PAIR_CYCLES != CYCLES_PER_PAIR) begin : g_bad_ppp
    $error("PIXELS_PER_PAIR disagrees with histogram_pkg");
  end

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] pair_q, pair_d, pair_inc;

  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    pair_inc = pair_q + 16'd1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SET_IN;
          pair_d  = '0;
        end
      end
      SET_IN:    state_d = WAIT_IN;
      WAIT_IN:   state_d = LATCH_IN;
      LATCH_IN:  state_d = SET_SCR;
      SET_SCR:   state_d = WAIT_SCR;
      WAIT_SCR:  state_d = LATCH_SCR;
      LATCH_SCR: state_d = WRITE;
      WRITE:     state_d = SHIFT;
      // SHIFT doubles as the write-settle cycle for back-to-back bins.
      SHIFT: begin
        if (!all_pixel_written) begin
          state_d = SET_SCR;
        end else begin
          pair_d  = pair_inc;
          state_d = (pair_inc == LAST_PAIR) ? DONE : SET_IN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      pair_q  <= pair_d;
    end
  end

  assign set_read_address_input_mem      = ctrl_q.set_in;
  assign read_data_ready_input_mem       = ctrl_q.rd_in;
  assign set_read_address_scratch_mem    = ctrl_q.set_scr;
  assign read_data_ready_scratch_mem     = ctrl_q.rd_scr;
  assign set_write_address_scratch_mem   = ctrl_q.wr_scr;
  assign shift_scratch_memory_rw_address = ctrl_q.shift;
  assign busy                            = ctrl_q.busy;
  assign done                            = ctrl_q.done;
  assign pair_count                      = pair_q;

endmodule

// File: tb/tb_histogram_control_path.sv
// Bench for histogram_control_path: cycle-exact schedule model
// with random start/flag noise and a small datapath model.
module tb_histogram_control_path;

  localparam int NP   = 4;
  localparam int PAIR = 3 + 5 * 32;
  localparam int L    = 1 + PAIR * NP;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        glitch = 1'b0;
  logic        all_pixel_written;
  logic        set_read_address_input_mem;
  logic        read_data_ready_input_mem;
  logic        set_read_address_scratch_mem;
  logic        read_data_ready_scratch_mem;
  logic        set_write_address_scratch_mem;
  logic        shift_scratch_memory_rw_address;
  logic        busy;
  logic        done;
  logic [15:0] pair_count;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int n_in, n_wr;

  always #5 clock = ~clock;

  histogram_control_path #(
    .NUM_PAIRS(NP),
    .PIXELS_PER_PAIR(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .all_pixel_written(all_pixel_written),
    .set_read_address_input_mem(set_read_address_input_mem),
    .read_data_ready_input_mem(read_data_ready_input_mem),
    .set_read_address_scratch_mem(set_read_address_scratch_mem),
    .read_data_ready_scratch_mem(read_data_ready_scratch_mem),
    .set_write_address_scratch_mem(set_write_address_scratch_mem),
    .shift_scratch_memory_rw_address(shift_scratch_memory_rw_address),
    .busy(busy),
    .done(done),
    .pair_count(pair_count)
  );

  // Datapath stand-in: flag rises once 32 writes of a pair are done.
  always @(posedge clock) begin
    if (reset || set_read_address_input_mem) wr_cnt <= 0;
    else if (set_write_address_scratch_mem) wr_cnt <= wr_cnt + 1;
  end
  assign all_pixel_written = (wr_cnt == 32) || glitch;

  wire [7:0] obs = {done, busy,
                    set_read_address_input_mem,
                    read_data_ready_input_mem,
                    set_read_address_scratch_mem,
                    read_data_ready_scratch_mem,
                    set_write_address_scratch_mem,
                    shift_scratch_memory_rw_address};

  // t = cycles since the IDLE cycle in which start was sampled.
  function automatic logic [7:0] exp_vec(input int t);
    logic [7:0] v;
    int r, q;
    v = '0;
    if (t >= 1 && t < L) begin
      v[6] = 1'b1;
      r = (t - 1) % PAIR;
      if (r == 0) v[5] = 1'b1;
      else if (r == 2) v[4] = 1'b1;
      else if (r >= 3) begin
        q = (r - 3) % 5;
        case (q)
          0: v[3] = 1'b1;
          2: v[2] = 1'b1;
          3: v[1] = 1'b1;
          4: v[0] = 1'b1;
          default: ;
        endcase
      end
    end else if (t == L) begin
      v[7] = 1'b1;
    end
    return v;
  endfunction

  task automatic check_out(input string tag,
                           input logic [7:0] e,
                           input logic [15:0] epc);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s outputs=%b expected=%b", tag, obs, e);
    end
    checks++;
    assert (pair_count === epc) else begin
      errors++;
      $error("FAIL %s pair_count=%0d expected=%0d",
             tag, pair_count, epc);
    end
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] pc);
    for (int i = 0; i < n; i++) begin
      check_out("idle", 8'h00, pc);
      start  = 1'b0;
      glitch = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
  endtask

  // Entered at the negedge of an IDLE cycle; drives start there.
  task automatic do_pass(input bit hold,
                         input logic [15:0] pc_prev,
                         input int reset_at);
    logic [7:0]  e;
    logic [15:0] epc;
    n_in = 0;
    n_wr = 0;
    for (int t = 0; t <= L; t++) begin
      e   = exp_vec(t);
      epc = (t == 0) ? pc_prev : 16'((t - 1) / PAIR);
      check_out($sformatf("pass_t%0d", t), e, epc);
      n_in += int'(set_read_address_input_mem);
      n_wr += int'(set_write_address_scratch_mem);
      if (t == reset_at) begin
        reset  = 1'b1;
        start  = 1'b0;
        glitch = 1'b0;
        @(negedge clock);
        check_out("mid_reset", 8'h00, 16'h0);
        reset = 1'b0;
        return;
      end
      if (t == 0) start = 1'b1;
      else if (t == L) start = hold;
      else start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      glitch = (e[0] == 1'b0) && ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    checks++;
    assert (n_in == NP) else begin
      errors++;
      $error("FAIL in_strobes got=%0d expected=%0d", n_in, NP);
    end
    checks++;
    assert (n_wr == 32 * NP) else begin
      errors++;
      $error("FAIL wr_strobes got=%0d expected=%0d",
             n_wr, 32 * NP);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'($urandom_range(0, 1));
    glitch = 1'($urandom_range(0, 1));
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check_out("reset", 8'h00, 16'h0);
      start  = 1'($urandom_range(0, 1));
      glitch = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    reset  = 1'b0;
    start  = 1'b0;
    glitch = 1'b0;
    @(negedge clock);
    idle_cycles($urandom_range(1, 4), 16'h0);

    do_pass(1'b0, 16'h0, -1);
    idle_cycles(3, 16'(NP));

    do_pass(1'b1, 16'(NP), -1);
    do_pass(1'b0, 16'(NP), -1);
    idle_cycles(2, 16'(NP));

    do_pass(1'b0, 16'(NP), 500);
    idle_cycles(2, 16'h0);
    do_pass(1'b0, 16'h0, -1);
    idle_cycles(2, 16'(NP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
